// File: rtl/pu_seq_pkg.sv
// Shared types and constants for the pu instruction sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pu_seq_pkg;

    localparam int CMDS   = 16;
    localparam int DEF_AW = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_FETCH = 2'd1,
        SEQ_EXEC  = 2'd2,
        SEQ_HALT  = 2'd3
    } seq_state_t;

    function automatic logic [CMDS-1:0] icnt_sat_inc(input logic [CMDS-1:0] v);
        return (v == '1) ? v : v + CMDS'(1);
    endfunction

endpackage

// File: rtl/pu_pc.sv
// Program counter: synchronous load to RST_PC, increment-enable, natural wrap at 2^AW.
// Latency: new value visible the cycle after load/inc is sampled.
// Backpressure: none; load has priority over inc.
module pu_pc #(
    parameter int            AW     = 8,
    parameter logic [AW-1:0] RST_PC = '0
) (
    input  logic          clk,
    input  logic          load,
    input  logic          inc,
    output logic [AW-1:0] pc
);

    always_ff @(posedge clk) begin
        if (load) begin
            pc <= RST_PC;
        end else if (inc) begin
            pc <= pc + AW'(1);
        end
    end

endmodule

// File: rtl/pu_seq.sv
// Instruction sequencer: fetch over req/ack, one-cycle execute strobe, HALT, retired counter.
// Latency: 2 cycles per instruction minimum, plus one FETCH cycle per cycle of ack latency.
// Backpressure: imem_req/imem_addr held until imem_ack; optional single-step under PU_STEP_EN.
module pu_seq
    import pu_seq_pkg::*;
#(
    parameter int            AW     = DEF_AW,
    parameter logic [AW-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
`ifdef PU_STEP_EN
    input  logic            step,
`endif
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic            imem_ack,
    input  logic [CMDS-1:0] imem_rdata,
    output logic [CMDS-1:0] ir,
    input  logic            h,
    output logic            exec,
    output logic [AW-1:0]   pc,
    output logic            busy,
    output logic            halted,
    output logic [CMDS-1:0] icnt
);

    seq_state_t state;
    logic       stop_pend;
    logic       run;
    logic       pc_inc;

`ifdef PU_STEP_EN
    logic run_q;
    assign run = run_q;
`else
    assign run = 1'b1;
`endif

    // A halting instruction keeps pc pointing at itself.
    assign pc_inc    = (state == SEQ_EXEC) && !h;
    assign imem_addr = pc;

    pu_pc #(
        .AW     (AW),
        .RST_PC (RST_PC)
    ) u_pc (
        .clk  (clk),
        .load (rst),
        .inc  (pc_inc),
        .pc   (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEQ_IDLE;
            ir        <= '0;
            icnt      <= '0;
            imem_req  <= 1'b0;
            exec      <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            stop_pend <= 1'b0;
`ifdef PU_STEP_EN
            run_q     <= 1'b0;
`endif
        end else begin
            exec <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (start && !stop) begin
                        state    <= SEQ_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
`ifdef PU_STEP_EN
                        run_q    <= 1'b1;
                    end else if (step) begin
                        state    <= SEQ_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                        run_q    <= 1'b0;
`endif
                    end
                end
                SEQ_FETCH: begin
                    // A stop here must not abandon the outstanding fetch.
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        state    <= SEQ_EXEC;
                        imem_req <= 1'b0;
                        exec     <= 1'b1;
                    end
                end
                SEQ_EXEC: begin
                    icnt      <= icnt_sat_inc(icnt);
                    stop_pend <= 1'b0;
                    if (h) begin
                        state  <= SEQ_HALT;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else if (stop || stop_pend || !run) begin
                        state <= SEQ_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= SEQ_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                SEQ_HALT: begin
                    state <= SEQ_HALT;
                end
                default: begin
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pu_seq.sv
// Directed bench for pu_seq: table of straight-line programs plus hand-written stop/reset/wrap/step sequences.
module tb_pu_seq;
    import pu_seq_pkg::*;

    localparam logic [15:0] HALT_W = 16'hF000;
    localparam logic [15:0] JUNK_W = 16'h5A5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, AW=8, RST_PC=0
    logic        rst = 1'b1, start = 1'b0, stop = 1'b0;
`ifdef PU_STEP_EN
    logic        step = 1'b0;
`endif
    logic        imem_req, imem_ack, h, exec, busy, halted;
    logic [7:0]  imem_addr, pc;
    logic [15:0] imem_rdata, ir, icnt;
    assign h = (ir == HALT_W);

    pu_seq #(.AW(8), .RST_PC(8'd0)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef PU_STEP_EN
        .step(step),
`endif
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir), .h(h), .exec(exec), .pc(pc),
        .busy(busy), .halted(halted), .icnt(icnt)
    );

    // Wrap instance, AW=2, RST_PC=3
    logic        rst2 = 1'b1, start2 = 1'b0, stop2 = 1'b0;
`ifdef PU_STEP_EN
    logic        step2 = 1'b0;
`endif
    logic        req2, ack2, h2, exec2, busy2, halted2;
    logic [1:0]  addr2, pc2;
    logic [15:0] rdata2, ir2, icnt2;
    assign h2 = (ir2 == HALT_W);

    pu_seq #(.AW(2), .RST_PC(2'd3)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .stop(stop2),
`ifdef PU_STEP_EN
        .step(step2),
`endif
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
        .imem_rdata(rdata2), .ir(ir2), .h(h2), .exec(exec2), .pc(pc2),
        .busy(busy2), .halted(halted2), .icnt(icnt2)
    );

    // Memory model / monitor state
    logic [15:0] mem [256];
    int  lat = 0;
    bit  spur = 1'b0;
    bit  clr_mon = 1'b0;
    int  exp_gap = 2;
    int  cyc, exec_cnt, last_exec, gap_bad, ir_bad, stab_bad, req_cycles, ack_cnt;
    logic req_p, ack_p, rst_p;
    logic [7:0] addr_p;

    int checks = 0;
    int failures = 0;

    initial begin : responder
        imem_ack = 1'b0; imem_rdata = '0;
        cyc = 0; exec_cnt = 0; last_exec = -1; gap_bad = 0; ir_bad = 0;
        stab_bad = 0; req_cycles = 0; ack_cnt = 0;
        req_p = 1'b0; ack_p = 1'b0; rst_p = 1'b1; addr_p = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr_mon) begin
                exec_cnt = 0; last_exec = -1; gap_bad = 0; ir_bad = 0;
                stab_bad = 0; req_cycles = 0;
            end else begin
                if (exec) begin
                    if (ir !== mem[pc]) ir_bad++;
                    if (last_exec >= 0 && (cyc - last_exec) != exp_gap) gap_bad++;
                    last_exec = cyc;
                    exec_cnt++;
                end
                if (req_p && !ack_p && !rst_p && (imem_req !== 1'b1 || imem_addr !== addr_p))
                    stab_bad++;
                if (imem_req) req_cycles++;
            end
            if (imem_req) begin
                if (ack_cnt >= lat) begin
                    imem_ack = 1'b1; imem_rdata = mem[imem_addr]; ack_cnt = 0;
                end else begin
                    imem_ack = 1'b0; imem_rdata = JUNK_W; ack_cnt++;
                end
            end else begin
                ack_cnt = 0; imem_ack = spur; imem_rdata = JUNK_W;
            end
            req_p = imem_req; ack_p = imem_ack; rst_p = rst; addr_p = imem_addr;
        end
    end

    initial begin : responder2
        ack2 = 1'b0; rdata2 = '0;
        forever begin
            @(negedge clk);
            ack2   = req2;
            rdata2 = (addr2 == 2'd0) ? HALT_W : 16'h0000;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        clr_mon = 1'b1; tick(); clr_mon = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (halted) break;
            tick();
        end
        chk(nm, 32'(halted), 32'd1);
    endtask

    task automatic load_prog(input int n_ops, input bit endless);
        logic [15:0] ops [4];
        ops[0] = 16'h0000; ops[1] = 16'h1234; ops[2] = 16'h2A55; ops[3] = 16'h3F0F;
        for (int a = 0; a < 256; a++) begin
            if (endless || a < n_ops) mem[a] = ops[a % 4];
            else if (a == n_ops)      mem[a] = HALT_W;
            else                      mem[a] = 16'h0000;
        end
    endtask

    typedef struct {
        int          n_ops;
        int          lat;
        bit          spur;
        logic [7:0]  exp_pc;
        logic [15:0] exp_icnt;
        int          exp_gap;
    } vec_t;

    initial begin : stim
        vec_t vt [4];
        vt[0] = '{2, 0, 1'b0, 8'd2, 16'd3, 2};
        vt[1] = '{2, 3, 1'b1, 8'd2, 16'd3, 5};
        vt[2] = '{5, 1, 1'b0, 8'd5, 16'd6, 3};
        vt[3] = '{0, 2, 1'b1, 8'd0, 16'd1, 4};
        load_prog(0, 1'b0);

        // Reset state
        tick();
        chk("rst_req",    32'(imem_req), 32'd0);
        chk("rst_exec",   32'(exec),     32'd0);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_halted", 32'(halted),   32'd0);
        chk("rst_pc",     32'(pc),       32'd0);
        chk("rst_icnt",   32'(icnt),     32'd0);
        chk("rst_ir",     32'(ir),       32'd0);
        rst = 1'b0;

        // Straight-line programs ending in HALT
        for (int v = 0; v < 4; v++) begin
            lat = vt[v].lat; spur = vt[v].spur; exp_gap = vt[v].exp_gap;
            load_prog(vt[v].n_ops, 1'b0);
            do_reset();
            pulse_start();
            chk($sformatf("v%0d_req_rise", v), 32'(imem_req), 32'd1);
            wait_halt(300, $sformatf("v%0d_halt_reached", v));
            repeat (4) tick();
            chk($sformatf("v%0d_pc", v),        32'(pc),      32'(vt[v].exp_pc));
            chk($sformatf("v%0d_icnt", v),      32'(icnt),    32'(vt[v].exp_icnt));
            chk($sformatf("v%0d_exec_cnt", v),  exec_cnt,     32'(vt[v].exp_icnt));
            chk($sformatf("v%0d_gap_bad", v),   gap_bad,      32'd0);
            chk($sformatf("v%0d_ir_bad", v),    ir_bad,       32'd0);
            chk($sformatf("v%0d_addr_stab", v), stab_bad,     32'd0);
            chk($sformatf("v%0d_ir_halt", v),   32'(ir),      32'(HALT_W));
            chk($sformatf("v%0d_busy", v),      32'(busy),    32'd0);
        end
        spur = 1'b0;

        // HALT ignores start/stop
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0; tick();
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_no_req", 32'(imem_req), 32'd0);

        // Stop during the second FETCH, then resume
        lat = 2; exp_gap = 4;
        load_prog(3, 1'b0);
        do_reset();
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (exec_cnt == 1 && imem_req) break;
            tick();
        end
        chk("stop_in_fetch2", 32'(imem_req), 32'd1);
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            tick();
        end
        repeat (3) tick();
        chk("stop_halted",   32'(halted),   32'd0);
        chk("stop_pc",       32'(pc),       32'd2);
        chk("stop_icnt",     32'(icnt),     32'd2);
        chk("stop_exec_cnt", exec_cnt,      32'd2);
        chk("stop_idle_req", 32'(imem_req), 32'd0);
        chk("stop_ir_bad",   ir_bad,        32'd0);
        clr_mon = 1'b1; tick(); clr_mon = 1'b0;
        pulse_start();
        chk("resume_req",  32'(imem_req),  32'd1);
        chk("resume_addr", 32'(imem_addr), 32'd2);
        wait_halt(100, "resume_halt_reached");
        chk("resume_pc",   32'(pc),   32'd3);
        chk("resume_icnt", 32'(icnt), 32'd4);

        // Start and stop together in IDLE: nothing happens
        lat = 0;
        do_reset();
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        repeat (5) tick();
        chk("startstop_req_cycles", req_cycles, 32'd0);
        chk("startstop_busy", 32'(busy), 32'd0);

        // Reset while a fetch is outstanding
        lat = 3;
        load_prog(0, 1'b1);
        do_reset();
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            if (exec_cnt == 2 && imem_req) break;
            tick();
        end
        chk("prerst_icnt", 32'(icnt), 32'd2);
        chk("prerst_req",  32'(imem_req), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_req",    32'(imem_req), 32'd0);
        chk("midrst_busy",   32'(busy),     32'd0);
        chk("midrst_pc",     32'(pc),       32'd0);
        chk("midrst_icnt",   32'(icnt),     32'd0);
        chk("midrst_ir",     32'(ir),       32'd0);
        chk("midrst_halted", 32'(halted),   32'd0);

        // Reset while exec is high
        do_reset();
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (exec) break;
            tick();
        end
        chk("exrst_seen_exec", 32'(exec), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("exrst_exec", 32'(exec), 32'd0);
        chk("exrst_icnt", 32'(icnt), 32'd0);
        tick();
        chk("exrst_exec_after", 32'(exec), 32'd0);
        chk("exrst_req_after",  32'(imem_req), 32'd0);

        // Address wrap on the AW=2 instance
        tick();
        chk("wrap_rst_pc", 32'(pc2), 32'd3);
        rst2 = 1'b0;
        start2 = 1'b1; tick(); start2 = 1'b0;
        chk("wrap_first_req",  32'(req2),  32'd1);
        chk("wrap_first_addr", 32'(addr2), 32'd3);
        for (int i = 0; i < 30; i++) begin
            if (halted2) break;
            tick();
        end
        chk("wrap_halted", 32'(halted2), 32'd1);
        chk("wrap_pc",     32'(pc2),     32'd0);
        chk("wrap_icnt",   32'(icnt2),   32'd2);
        chk("wrap_busy",   32'(busy2),   32'd0);
        chk("wrap_exec",   32'(exec2),   32'd0);

`ifdef PU_STEP_EN
        // Single-step twice
        lat = 0; exp_gap = 0;
        load_prog(2, 1'b0);
        do_reset();
        step = 1'b1; tick(); step = 1'b0;
        chk("step1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick();
        end
        repeat (2) tick();
        chk("step1_icnt", 32'(icnt), 32'd1);
        chk("step1_pc",   32'(pc),   32'd1);
        chk("step1_idle", 32'(busy), 32'd0);
        chk("step1_req",  32'(imem_req), 32'd0);
        step = 1'b1; tick(); step = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick();
        end
        repeat (2) tick();
        chk("step2_icnt",     32'(icnt),   32'd2);
        chk("step2_pc",       32'(pc),     32'd2);
        chk("step2_exec_cnt", exec_cnt,    32'd2);
        chk("step2_halted",   32'(halted), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
